// File: rtl/hht_mem_responder_if.sv
// hht_mem_responder_if: config, preload stream and dual read-port bus; HHT_MEM_STATS_EN adds hit/miss counter outputs
interface hht_mem_responder_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          start;
  logic [AW-1:0] wdata_col_base;
  logic [31:0]   csize;
  logic [AW-1:0] v_values_base;
  logic [31:0]   vsize;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dataIn1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] dataIn2;
  logic          ready;
  logic          cfg_err;
`ifdef HHT_MEM_STATS_EN
  logic [31:0]   hit_cnt1;
  logic [31:0]   hit_cnt2;
  logic [31:0]   miss_cnt;
  modport master(
    output start, wdata_col_base, csize, v_values_base, vsize, ld_valid, ld_data, addr1, addr2,
    input  ld_ready, dataIn1, dataIn2, ready, cfg_err, hit_cnt1, hit_cnt2, miss_cnt
  );
  modport slave(
    input  start, wdata_col_base, csize, v_values_base, vsize, ld_valid, ld_data, addr1, addr2,
    output ld_ready, dataIn1, dataIn2, ready, cfg_err, hit_cnt1, hit_cnt2, miss_cnt
  );
`else
  modport master(
    output start, wdata_col_base, csize, v_values_base, vsize, ld_valid, ld_data, addr1, addr2,
    input  ld_ready, dataIn1, dataIn2, ready, cfg_err
  );
  modport slave(
    input  start, wdata_col_base, csize, v_values_base, vsize, ld_valid, ld_data, addr1, addr2,
    output ld_ready, dataIn1, dataIn2, ready, cfg_err
  );
`endif
endinterface

// File: rtl/hht_mem_responder.sv
// hht_mem_responder: preloaded column/v-value memory answering control's two read ports; HHT_MEM_STATS_EN adds hit/miss counters
module hht_mem_responder #(
  parameter int            COL_DEPTH = 256,
  parameter int            V_DEPTH   = 16,
  parameter int            DW        = 32,
  parameter int            AW        = 32,
  parameter int            RD_LAT    = 0,
  parameter logic [DW-1:0] MISS_VAL  = DW'(99999)
) (
  input logic Clk,
  input logic Rst,
  hht_mem_responder_if.slave bus
);
  localparam int CAW = $clog2(COL_DEPTH);
  localparam int VAW = $clog2(V_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD_COL, LOAD_V, READY} state_t;
  state_t        state;
  logic [31:0]   cnt;
  logic [AW-1:0] base1, base2;
  logic [31:0]   size1, size2;
  logic          ld_ready_q, ready_q, cfg_err_q;
  logic          bad_cfg, last;
  logic [DW-1:0] col_mem [COL_DEPTH];
  logic [DW-1:0] v_mem [V_DEPTH];
  logic [AW:0]   off1, off2;
  logic          hit1, hit2;
  logic [DW-1:0] rd1, rd2;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ready    = ready_q;
  assign bus.cfg_err  = cfg_err_q;
  // config legality and last-beat detection for the active load phase
  always_comb begin
    bad_cfg = bus.csize == 32'd0 || bus.csize > 32'(COL_DEPTH) || bus.vsize == 32'd0 || bus.vsize > 32'(V_DEPTH);
    last    = cnt == (state == LOAD_COL ? size1 : size2) - 32'd1;
  end
  // control FSM: start always wins, aborting any load in progress
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_ready_q <= 1'b0;
      ready_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
      base1      <= '0;
      size1      <= '0;
      base2      <= '0;
      size2      <= '0;
    end else if (bus.start) begin
      base1      <= bus.wdata_col_base;
      size1      <= bus.csize;
      base2      <= bus.v_values_base;
      size2      <= bus.vsize;
      cnt        <= '0;
      ready_q    <= 1'b0;
      cfg_err_q  <= bad_cfg;
      ld_ready_q <= !bad_cfg;
      state      <= bad_cfg ? IDLE : LOAD_COL;
    end else if (bus.ld_valid && ld_ready_q) begin
      cnt <= last ? '0 : cnt + 32'd1;
      if (last && state == LOAD_COL) state <= LOAD_V;
      if (last && state == LOAD_V) begin
        state      <= READY;
        ld_ready_q <= 1'b0;
        ready_q    <= 1'b1;
      end
    end
  // preload storage; contents survive reset and are only replaced by a reload
  always_ff @(posedge Clk)
    if (bus.ld_valid && !bus.start) begin
      if (state == LOAD_COL) col_mem[cnt[CAW-1:0]] <= bus.ld_data;
      if (state == LOAD_V) v_mem[cnt[VAW-1:0]] <= bus.ld_data;
    end
  // window decode with a borrow bit so addresses below base never alias into the window
  always_comb begin
    off1 = {1'b0, bus.addr1} - {1'b0, base1};
    off2 = {1'b0, bus.addr2} - {1'b0, base2};
    hit1 = ready_q && !off1[AW] && off1[AW-1:0] < size1;
    hit2 = ready_q && !off2[AW] && off2[AW-1:0] < size2;
    rd1  = hit1 ? col_mem[off1[CAW-1:0]] : MISS_VAL;
    rd2  = hit2 ? v_mem[off2[VAW-1:0]] : MISS_VAL;
  end
  if (RD_LAT == 0) begin : g_comb
    assign bus.dataIn1 = rd1;
    assign bus.dataIn2 = rd2;
  end else begin : g_reg
    logic [DW-1:0] q1, q2;
    // output registers give one cycle of address-to-data latency
    always_ff @(posedge Clk or negedge Rst)
      if (!Rst) begin
        q1 <= MISS_VAL;
        q2 <= MISS_VAL;
      end else begin
        q1 <= rd1;
        q2 <= rd2;
      end
    assign bus.dataIn1 = q1;
    assign bus.dataIn2 = q2;
  end
`ifdef HHT_MEM_STATS_EN
  logic [31:0] h1_q, h2_q, miss_q;
  logic [32:0] miss_sum;
  assign bus.hit_cnt1 = h1_q;
  assign bus.hit_cnt2 = h2_q;
  assign bus.miss_cnt = miss_q;
  // both ports can miss in the same cycle, so the miss sum needs a carry bit for saturation
  always_comb miss_sum = {1'b0, miss_q} + {32'd0, !hit1} + {32'd0, !hit2};
  // saturating per-cycle hit/miss counters, cleared on any start
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      h1_q   <= '0;
      h2_q   <= '0;
      miss_q <= '0;
    end else if (bus.start) begin
      h1_q   <= '0;
      h2_q   <= '0;
      miss_q <= '0;
    end else if (ready_q) begin
      h1_q   <= hit1 && h1_q != '1 ? h1_q + 32'd1 : h1_q;
      h2_q   <= hit2 && h2_q != '1 ? h2_q + 32'd1 : h2_q;
      miss_q <= miss_sum[32] ? '1 : miss_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_hht_mem_responder.sv
// tb_hht_mem_responder: randomized scoreboard bench for the combinational and registered-read builds
`timescale 1ns/1ps
module tb_hht_mem_responder;
  localparam logic [31:0] MISS = 32'd99999;
  typedef struct {int k; logic [31:0] v;} chk_t;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;
  hht_mem_responder_if bus();
  hht_mem_responder_if bus_r();
  hht_mem_responder dut (.Clk(Clk), .Rst(Rst), .bus(bus.slave));
  hht_mem_responder #(.RD_LAT(1)) dut_r (.Clk(Clk), .Rst(Rst), .bus(bus_r.slave));
  assign bus_r.start          = bus.start;
  assign bus_r.wdata_col_base = bus.wdata_col_base;
  assign bus_r.csize          = bus.csize;
  assign bus_r.v_values_base  = bus.v_values_base;
  assign bus_r.vsize          = bus.vsize;
  assign bus_r.ld_valid       = bus.ld_valid;
  assign bus_r.ld_data        = bus.ld_data;
  assign bus_r.addr1          = bus.addr1;
  assign bus_r.addr2          = bus.addr2;
  chk_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  // reference model: window config, memory images, beats accepted since last legal start
  logic [31:0] m_col [256];
  logic [31:0] m_v [16];
  logic [31:0] m_b1, m_c1, m_b2, m_v2;
  bit          m_load, m_err;
  longint      m_n;
  logic [31:0] m_prev1, m_prev2;
  longint      m_h1, m_h2, m_m;
  function automatic longint tot();
    return longint'(m_c1) + longint'(m_v2);
  endfunction
  function automatic bit m_ready();
    return m_load && m_n == tot();
  endfunction
  function automatic bit m_hit(input int p, input logic [31:0] a);
    longint off = longint'(a) - longint'(p == 1 ? m_b1 : m_b2);
    return m_ready() && off >= 0 && off < longint'(p == 1 ? m_c1 : m_v2);
  endfunction
  function automatic logic [31:0] exp_rd(input int p, input logic [31:0] a);
    longint off = longint'(a) - longint'(p == 1 ? m_b1 : m_b2);
    if (!m_hit(p, a)) return MISS;
    return p == 1 ? m_col[off] : m_v[off];
  endfunction
  function automatic longint sat(input longint x);
    return x > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : x;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", n, cyc_n, got, exp);
    end
  endtask
  task automatic m_reset();
    m_load = 0; m_err = 0; m_n = 0;
    m_prev1 = MISS; m_prev2 = MISS;
    m_h1 = 0; m_h2 = 0; m_m = 0;
    m_b1 = 0; m_c1 = 0; m_b2 = 0; m_v2 = 0;
  endtask
  // apply one clock edge to the model using the inputs that were held across it
  task automatic model_edge();
    logic [31:0] e1, e2;
    if (!Rst) begin
      m_reset();
      return;
    end
    e1 = exp_rd(1, bus.addr1);
    e2 = exp_rd(2, bus.addr2);
    if (bus.start) begin
      m_b1 = bus.wdata_col_base; m_c1 = bus.csize; m_b2 = bus.v_values_base; m_v2 = bus.vsize;
      m_err = m_c1 == 0 || m_c1 > 256 || m_v2 == 0 || m_v2 > 16;
      m_load = !m_err; m_n = 0;
      m_h1 = 0; m_h2 = 0; m_m = 0;
    end else begin
      if (m_ready()) begin
        m_h1 = sat(m_h1 + longint'(m_hit(1, bus.addr1)));
        m_h2 = sat(m_h2 + longint'(m_hit(2, bus.addr2)));
        m_m  = sat(m_m + longint'(!m_hit(1, bus.addr1)) + longint'(!m_hit(2, bus.addr2)));
      end
      if (m_load && m_n < tot() && bus.ld_valid) begin
        if (m_n < longint'(m_c1)) m_col[m_n] = bus.ld_data;
        else m_v[m_n - longint'(m_c1)] = bus.ld_data;
        m_n++;
      end
    end
    m_prev1 = e1;
    m_prev2 = e2;
  endtask
  task automatic push(input int k, input logic [31:0] v);
    chk_t c;
    c.k = k;
    c.v = v;
    sb.push_back(c);
  endtask
  task automatic push_checks();
    push(0, {31'd0, m_load && m_n < tot()});
    push(1, {31'd0, m_ready()});
    push(2, {31'd0, m_err});
    push(3, exp_rd(1, bus.addr1));
    push(4, exp_rd(2, bus.addr2));
    push(5, m_prev1);
    push(6, m_prev2);
    push(7, {31'd0, m_ready()});
`ifdef HHT_MEM_STATS_EN
    push(8, m_h1[31:0]);
    push(9, m_h2[31:0]);
    push(10, m_m[31:0]);
`endif
  endtask
  function automatic logic [31:0] act(input int k);
    case (k)
      0: return {31'd0, bus.ld_ready};
      1: return {31'd0, bus.ready};
      2: return {31'd0, bus.cfg_err};
      3: return bus.dataIn1;
      4: return bus.dataIn2;
      5: return bus_r.dataIn1;
      6: return bus_r.dataIn2;
      7: return {31'd0, bus_r.ready};
`ifdef HHT_MEM_STATS_EN
      8: return bus.hit_cnt1;
      9: return bus.hit_cnt2;
      10: return bus.miss_cnt;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  function automatic string nm(input int k);
    case (k)
      0: return "ld_ready";
      1: return "ready";
      2: return "cfg_err";
      3: return "dataIn1";
      4: return "dataIn2";
      5: return "lat1_dataIn1";
      6: return "lat1_dataIn2";
      7: return "lat1_ready";
      8: return "hit_cnt1";
      9: return "hit_cnt2";
      default: return "miss_cnt";
    endcase
  endfunction
  // monitor: compare every queued expectation against the DUT mid-cycle
  always @(negedge Clk) begin
    chk_t c;
    logic [31:0] a;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      a = act(c.k);
      checks++;
      if (a !== c.v) begin
        errors++;
        $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm(c.k), cyc_n, a, c.v);
      end
    end
  end
  task automatic cyc(input logic st, input logic lv, input logic [31:0] d, input logic [31:0] a1, input logic [31:0] a2);
    bus.start = st; bus.ld_valid = lv; bus.ld_data = d; bus.addr1 = a1; bus.addr2 = a2;
    push_checks();
    @(posedge Clk);
    #1;
    cyc_n++;
    model_edge();
  endtask
  function automatic logic [31:0] rnd_addr(input int p);
    logic [31:0] b, s;
    b = p == 1 ? m_b1 : m_b2;
    s = p == 1 ? m_c1 : m_v2;
    case ($urandom_range(5))
      0: return b - 32'd1;
      1: return b;
      2: return b + s - 32'd1;
      3: return b + s;
      4: return b + $urandom_range(s > 0 ? s - 1 : 0);
      default: return $urandom;
    endcase
  endfunction
  task automatic do_start(input logic [31:0] b1, input logic [31:0] c1, input logic [31:0] b2, input logic [31:0] v2);
    bus.wdata_col_base = b1; bus.csize = c1; bus.v_values_base = b2; bus.vsize = v2;
    cyc(1'b1, 1'($urandom_range(1)), $urandom, rnd_addr(1), rnd_addr(2));
  endtask
  task automatic load(input int pct, input bit fix, input int abort_at);
    logic lv;
    logic [31:0] d;
    for (int i = 0; i < 4000 && !m_ready(); i++) begin
      lv = $urandom_range(99) < pct;
      d = $urandom;
      if (fix && m_n == 0) d = 32'd15;
      if (fix && m_n == tot() - 1) d = 32'd34;
      cyc(1'b0, lv, d, rnd_addr(1), rnd_addr(2));
      if (abort_at > 0 && m_n == abort_at) return;
    end
    chk("load_timeout", {31'd0, m_ready()}, 32'd1);
  endtask
  task automatic reads(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(1)), $urandom, rnd_addr(1), rnd_addr(2));
  endtask
  initial begin
    m_reset();
    bus.start = 0; bus.ld_valid = 0; bus.ld_data = 0; bus.addr1 = 0; bus.addr2 = 0;
    bus.wdata_col_base = 0; bus.csize = 0; bus.v_values_base = 0; bus.vsize = 0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom, $urandom, $urandom);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
    chk("rst_dataIn1", bus.dataIn1, MISS);
    chk("rst_dataIn2", bus.dataIn2, MISS);
    chk("rst_lat1_dataIn1", bus_r.dataIn1, MISS);
    chk("rst_lat1_dataIn2", bus_r.dataIn2, MISS);
    Rst = 1'b1;
    reads(2);
    do_start(32'd180, 32'd230, 32'd2, 32'd16);
    load(100, 1'b1, 0);
    cyc(1'b0, 1'b0, 0, 32'd180, 32'd17);
    cyc(1'b0, 1'b1, $urandom, 32'd179, 32'd18);
    cyc(1'b0, 1'b1, $urandom, 32'd410, 32'd1);
    cyc(1'b0, 1'b0, 0, 32'd409, 32'd2);
    reads(60);
    do_start(32'd180, 32'd230, 32'd2, 32'd16);
    load(100, 1'b0, 50);
    do_start(32'd180, 32'd230, 32'd2, 32'd16);
    load(70, 1'b0, 0);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 0, 32'd180 + 32'(i), rnd_addr(2));
    reads(20);
    do_start(32'd180, 32'd0, 32'd2, 32'd16);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom, rnd_addr(1), rnd_addr(2));
    do_start(32'd5, 32'd257, 32'd2, 32'd16);
    do_start(32'd5, 32'd10, 32'd2, 32'd17);
    do_start(32'd5, 32'd10, 32'd2, 32'd0);
    do_start(32'hFFFF_FF80, 32'd256, 32'hFFFF_FFF8, 32'd16);
    load(60, 1'b0, 0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 0, 32'hFFFF_FF80 + 32'($urandom_range(255)), 32'd100 + 32'(i));
    cyc(1'b0, 1'b0, 0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    reads(80);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        Rst = 1'b0;
        m_reset();
      end
      cyc(1'b0, 1'b0, 0, m_b1 + 32'(i), rnd_addr(2));
    end
    Rst = 1'b1;
    reads(3);
    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hht_mem_responder.md
Name: hht_mem_responder

Overview:
- Memory-side responder for the HHT `control` block. It serves the two read ports `control` drives: `addr1`/`dataIn1` for column data and `addr2`/`dataIn2` for v-values.
- Before operation it is preloaded from a valid/ready load stream: column words first, then v-value words.
- After preload it answers reads inside the programmed address windows and returns a fixed miss value outside them.
- It replaces behavioural case-table memories, so the same responder serves 16x16 and 32x32 runs.

Parameters:
- COL_DEPTH, 256: column storage words; maximum csize.
- V_DEPTH, 16: v-value storage words.
- DW, 32: data width.
- AW, 32: address width.
- RD_LAT, 0: read latency in cycles. 0 = combinational, matching the `control` timing; 1 = registered output.
- MISS_VAL, 32'd99999: value returned for any out-of-window or not-ready read.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches the window config and begins preload.
- wdata_col_base  in  AW  column window base address.
- csize  in  32  column word count, 1..COL_DEPTH.
- v_values_base  in  AW  v window base address.
- vsize  in  32  v word count, 1..V_DEPTH.
- ld_valid  in  1  load word valid.
- ld_data  in  DW  load word.
- ld_ready  out  1  responder accepts a load word.
- addr1  in  AW  column read address.
- dataIn1  out  DW  column read data.
- addr2  in  AW  v read address.
- dataIn2  out  DW  v read data.
- ready  out  1  preload complete; reads are valid.
- cfg_err  out  1  sticky; start was given with an illegal size.

Behaviour:
- Reset (Rst=0, async):
  - state=IDLE; ld_ready=0, ready=0, cfg_err=0.
  - dataIn1=dataIn2=MISS_VAL; load counter=0.
  - Storage contents are not cleared.
- States: IDLE, LOAD_COL, LOAD_V, READY.
- IDLE:
  - On start, latch the four config inputs.
  - If csize==0, csize>COL_DEPTH, vsize==0 or vsize>V_DEPTH: set cfg_err and stay in IDLE.
  - Otherwise clear cfg_err, clear the counter and go to LOAD_COL.
- LOAD_COL:
  - ld_ready=1. Each ld_valid&ld_ready cycle writes col_mem[cnt] and increments cnt.
  - The beat with cnt==csize-1 moves to LOAD_V with cnt=0.
- LOAD_V:
  - Same handshake, writing v_mem.
  - The beat with cnt==vsize-1 moves to READY.
  - ready asserts the cycle after that last beat.
- READY:
  - ld_ready=0; extra load beats are ignored, with no write and no counter change.
  - start in READY re-latches the config, deasserts ready and restarts preload (same legality check).
- start during LOAD_COL or LOAD_V: abort, re-latch the config and restart at LOAD_COL with cnt=0. Partially loaded words stay stale but are overwritten by the reload.
- Handshake: ld_ready depends only on state, never on ld_valid. ld_valid with ld_ready=0 is a no-op.
- Read decode (all reads use the latched config):
  - Port 1 hits when base1 <= addr1 < base1+csize1. The offset is computed in 33 bits, so base+size overflow past 2^32 counts as a miss, not a wrap.
  - On a hit, dataIn1=col_mem[addr1-base1]; otherwise MISS_VAL. Port 2 is the same with the v window.
  - When ready=0, both outputs return MISS_VAL regardless of address.
- Timing:
  - RD_LAT=0: the outputs follow the addresses combinationally, registered storage read asynchronously.
  - RD_LAT=1: the outputs are registered with address-to-data latency of 1 cycle, and the output registers reset to MISS_VAL.
- Both ports are fully independent; simultaneous reads to the same or overlapping addresses are legal.
- Overlapping windows: port 1 reads only col_mem and port 2 reads only v_mem; there is no cross-aliasing.

Optional Feature:
- HHT_MEM_STATS_EN defined adds three outputs:
  - hit_cnt1 (32): port-1 hits.
  - hit_cnt2 (32): port-2 hits.
  - miss_cnt (32): misses on either port; a cycle where both ports miss counts +2.
- Counting rules:
  - Counted once per Clk cycle while ready=1, using the current addresses.
  - Counters saturate at all-ones.
  - Cleared by reset and by any accepted start.
- Undefined: these ports and counters are absent, and the behaviour is otherwise identical.

Test Plan:
- Reset, then start with base1=180, csize=230, base2=2, vsize=16. Stream 230 column words then 16 v words with ld_valid held at 1 -> ld_ready high for 246 cycles; ready asserts the cycle after the 246th beat; addr1=180 returns word0 (15); addr2=17 returns 34.
- After ready: addr1=179, addr1=410, addr2=18 -> all return 99999. addr1=409 -> returns the last column word.
- Assert start mid-LOAD_COL after 50 beats, then complete a full reload with new data -> the first 50 addresses return the new data; ready stays 0 until the reload finishes.
- start with csize=0 -> cfg_err=1, state stays IDLE, ld_ready=0. Then a legal start -> cfg_err clears.
- RD_LAT=1 build, ready asserted: sweep addr1 per cycle -> dataIn1 lags addr1 by exactly 1 cycle. Drop Rst mid-sweep -> dataIn1=99999 immediately and ready=0.
- HHT_MEM_STATS_EN: after load, 10 cycles with addr1 in-window and addr2 out-of-window -> hit_cnt1=10, hit_cnt2=0, miss_cnt=10.
